// File: rtl/irq_iack_seq_pkg.sv
// Shared types and constants for the sub-CPU interrupt-acknowledge sequencer.
package irq_iack_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WAIT,
    DONE
  } iack_state_e;

  localparam logic [2:0] FC_CPU_SPACE = 3'b111;
  localparam logic [2:0] IPL_NONE     = 3'b111;
  localparam logic [2:0] LEVEL_NMI    = 3'd7;

endpackage

// File: rtl/irq_iack_seq_ipl_filter.sv
// IPL input conditioning: two-stage synchroniser, 68000-style equality filter
// and the level-7 edge latch that makes NMI non-maskable but edge triggered.
module irq_iack_seq_ipl_filter
  import irq_iack_seq_pkg::*;
(
  input  logic       clk_asic,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] cpu_ipl,
  input  logic       nmi_clr,
  output logic [2:0] irq_level,
  output logic       nmi_latch
);

  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] stable;
  logic       samples_agree;
  logic       nmi_edge;

  assign samples_agree = (sync1 == sync2);
  // Level 7 is encoded active low as 000; only a fresh transition into it counts.
  assign nmi_edge      = samples_agree && (sync1 == 3'b000) && (stable != 3'b000);
  assign irq_level     = ~stable;

  always_ff @(negedge clk_asic) begin
    if (rst) begin
      sync1     <= IPL_NONE;
      sync2     <= IPL_NONE;
      stable    <= IPL_NONE;
      nmi_latch <= 1'b0;
    end else if (en) begin
      sync1 <= cpu_ipl;
      sync2 <= sync1;
      if (samples_agree) begin
        stable <= sync1;
      end
      if (nmi_edge) begin
        nmi_latch <= 1'b1;
      end else if (nmi_clr) begin
        nmi_latch <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/irq_iack_seq.sv
// Interrupt-acknowledge initiator for the sub-CPU core: turns a filtered IPL
// into a 68000-style IACK bus cycle and hands the resulting vector to the core.
module irq_iack_seq
  import irq_iack_seq_pkg::*;
#(
  parameter int         TIMEOUT   = 32,
  parameter logic [7:0] AUTO_BASE = 8'd24,
  parameter logic [7:0] SPUR_VEC  = 8'd24
) (
  input  logic       clk_asic,
  input  logic       rst,
  input  logic       sub_sync,
  input  logic [2:0] cpu_ipl,
  input  logic [2:0] sr_mask,
  input  logic       iack_start,
  output logic       irq_req,
  output logic [2:0] irq_level,
  output logic       iack_done,
  output logic [7:0] iack_vector,
  output logic       iack_auto,
  output logic [2:0] bus_fc,
  output logic [2:0] bus_addr,
  output logic       bus_oe,
  input  logic       bus_vpa,
  input  logic       bus_dtack,
  input  logic [7:0] bus_data
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  iack_state_e      state;
  logic [2:0]       ack_lvl;
  logic [CNT_W-1:0] wait_cnt;
  logic             nmi_latch;
  logic             nmi_clr;
  logic             cycle_ends;

  // Only completing a level-7 acknowledge re-arms the NMI edge detector.
  assign nmi_clr    = (state == DONE) && (ack_lvl == LEVEL_NMI);
  assign cycle_ends = !bus_vpa || !bus_dtack || (wait_cnt == CNT_LAST);

  irq_iack_seq_ipl_filter u_ipl_filter (
    .clk_asic  (clk_asic),
    .rst       (rst),
    .en        (sub_sync),
    .cpu_ipl   (cpu_ipl),
    .nmi_clr   (nmi_clr),
    .irq_level (irq_level),
    .nmi_latch (nmi_latch)
  );

  always_ff @(negedge clk_asic) begin
    if (rst) begin
      irq_req <= 1'b0;
    end else if (sub_sync) begin
      irq_req <= ((irq_level > sr_mask) && (irq_level != LEVEL_NMI)) || nmi_latch;
    end
  end

  // Bus outputs are registered and take the value of the state being entered.
  always_ff @(negedge clk_asic) begin
    if (rst) begin
      state       <= IDLE;
      ack_lvl     <= 3'd0;
      wait_cnt    <= '0;
      bus_fc      <= 3'd0;
      bus_addr    <= 3'd0;
      bus_oe      <= 1'b1;
      iack_done   <= 1'b0;
      iack_vector <= 8'd0;
      iack_auto   <= 1'b0;
    end else if (sub_sync) begin
      case (state)
        IDLE: begin
          if (iack_start && irq_req) begin
            ack_lvl  <= irq_level;
            bus_fc   <= FC_CPU_SPACE;
            bus_addr <= irq_level;
            bus_oe   <= 1'b1;
            state    <= ADDR;
          end
        end
        ADDR: begin
          bus_oe   <= 1'b0;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (!bus_vpa) begin
            iack_vector <= AUTO_BASE + {5'd0, ack_lvl};
            iack_auto   <= 1'b1;
          end else if (!bus_dtack) begin
            iack_vector <= bus_data;
            iack_auto   <= 1'b0;
          end else if (wait_cnt == CNT_LAST) begin
            iack_vector <= SPUR_VEC;
            iack_auto   <= 1'b0;
          end
          if (cycle_ends) begin
            bus_oe    <= 1'b1;
            bus_fc    <= 3'd0;
            bus_addr  <= 3'd0;
            iack_done <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          iack_done <= 1'b0;
          wait_cnt  <= '0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_iack_seq.sv
// Self-checking bench for irq_iack_seq: directed scenarios plus randomized
// IACK transactions checked against a transaction-level expectation model.
module tb_irq_iack_seq;

  localparam int         TIMEOUT   = 32;
  localparam logic [7:0] AUTO_BASE = 8'd24;
  localparam logic [7:0] SPUR_VEC  = 8'd24;

  logic       clk_asic = 1'b0;
  logic       rst;
  logic       sub_sync;
  logic [2:0] cpu_ipl;
  logic [2:0] sr_mask;
  logic       iack_start;
  logic       bus_vpa;
  logic       bus_dtack;
  logic [7:0] bus_data;
  logic       irq_req;
  logic [2:0] irq_level;
  logic       iack_done;
  logic [7:0] iack_vector;
  logic       iack_auto;
  logic [2:0] bus_fc;
  logic [2:0] bus_addr;
  logic       bus_oe;

  int checks   = 0;
  int failures = 0;
  logic [7:0] last_vec  = 8'd0;
  logic       last_auto = 1'b0;

  irq_iack_seq dut (
    .clk_asic    (clk_asic),
    .rst         (rst),
    .sub_sync    (sub_sync),
    .cpu_ipl     (cpu_ipl),
    .sr_mask     (sr_mask),
    .iack_start  (iack_start),
    .irq_req     (irq_req),
    .irq_level   (irq_level),
    .iack_done   (iack_done),
    .iack_vector (iack_vector),
    .iack_auto   (iack_auto),
    .bus_fc      (bus_fc),
    .bus_addr    (bus_addr),
    .bus_oe      (bus_oe),
    .bus_vpa     (bus_vpa),
    .bus_dtack   (bus_dtack),
    .bus_data    (bus_data)
  );

  always #5 clk_asic = ~clk_asic;

  // The DUT updates on the falling edge; the bench drives and samples on the rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_asic);
  endtask

  task automatic set_level(input logic [2:0] lvl);
    cpu_ipl = ~lvl;
    tick(5);
  endtask

  // resp: 0 = VPA, 1 = DTACK, 2 = no response, 3 = VPA and DTACK together
  task automatic do_iack(input logic [2:0] lvl, input int resp, input int delay,
                         input logic [7:0] data, input bit wiggle);
    logic [7:0] exp_vec;
    logic       exp_auto;
    int         exp_cycles;
    int         cyc;
    logic [2:0] alt_lvl;
    exp_auto   = (resp == 0) || (resp == 3);
    exp_vec    = exp_auto ? AUTO_BASE + 8'(lvl) : (resp == 1) ? data : SPUR_VEC;
    exp_cycles = (resp == 2) ? TIMEOUT : delay + 1;
    alt_lvl    = 3'((lvl % 6) + 1);

    iack_start = 1'b1;
    tick(1);
    iack_start = 1'b0;
    checks++;
    if (bus_fc !== 3'b111 || bus_addr !== lvl || bus_oe !== 1'b1) begin
      failures++;
      $display("[TB] FAIL iack_addr_phase: fc=%0d addr=%0d oe=%0b required fc=7 addr=%0d oe=1",
               bus_fc, bus_addr, bus_oe, lvl);
    end
    tick(1);

    cyc = 0;
    while (iack_done !== 1'b1 && cyc < TIMEOUT + 8) begin
      checks++;
      if (bus_addr !== lvl || bus_fc !== 3'b111 || bus_oe !== 1'b0) begin
        failures++;
        $display("[TB] FAIL iack_wait_bus: fc=%0d addr=%0d oe=%0b required fc=7 addr=%0d oe=0",
                 bus_fc, bus_addr, bus_oe, lvl);
      end
      if (wiggle && cyc == 0) cpu_ipl = ~alt_lvl;
      if (resp != 2 && cyc >= delay) begin
        bus_vpa   = !exp_auto;
        bus_dtack = !((resp == 1) || (resp == 3));
        bus_data  = data;
      end
      tick(1);
      cyc++;
    end

    checks++;
    if (iack_done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL iack_done_bound: iack_done=%0b after %0d cycles, required 1", iack_done, cyc);
    end
    checks++;
    if (cyc != exp_cycles) begin
      failures++;
      $display("[TB] FAIL iack_length: wait cycles=%0d required %0d", cyc, exp_cycles);
    end
    checks++;
    if (iack_vector !== exp_vec || iack_auto !== exp_auto) begin
      failures++;
      $display("[TB] FAIL iack_vector: vec=%0d auto=%0b required vec=%0d auto=%0b",
               iack_vector, iack_auto, exp_vec, exp_auto);
    end
    checks++;
    if (bus_oe !== 1'b1 || bus_fc !== 3'd0 || bus_addr !== 3'd0) begin
      failures++;
      $display("[TB] FAIL iack_bus_release: oe=%0b fc=%0d addr=%0d required oe=1 fc=0 addr=0",
               bus_oe, bus_fc, bus_addr);
    end

    bus_vpa   = 1'b1;
    bus_dtack = 1'b1;
    cpu_ipl   = ~lvl;
    tick(1);
    checks++;
    if (iack_done !== 1'b0 || iack_vector !== exp_vec || iack_auto !== exp_auto) begin
      failures++;
      $display("[TB] FAIL iack_done_pulse: done=%0b vec=%0d auto=%0b required done=0 vec=%0d auto=%0b",
               iack_done, iack_vector, iack_auto, exp_vec, exp_auto);
    end
    last_vec  = exp_vec;
    last_auto = exp_auto;
  endtask

  task automatic test_reset();
    rst = 1'b1; sub_sync = 1'b1; cpu_ipl = 3'b111; sr_mask = 3'd0;
    iack_start = 1'b0; bus_vpa = 1'b1; bus_dtack = 1'b1; bus_data = 8'd0;
    tick(3);
    checks++;
    if (bus_oe !== 1'b1 || bus_fc !== 3'd0 || bus_addr !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset_bus: oe=%0b fc=%0d addr=%0d required 1/0/0", bus_oe, bus_fc, bus_addr);
    end
    checks++;
    if (irq_req !== 1'b0 || irq_level !== 3'd0 || iack_done !== 1'b0 ||
        iack_vector !== 8'd0 || iack_auto !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_core: req=%0b lvl=%0d done=%0b vec=%0d auto=%0b required all 0",
               irq_req, irq_level, iack_done, iack_vector, iack_auto);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_vpa();
    sr_mask = 3'd3;
    cpu_ipl = 3'b010;
    tick(2);
    checks++;
    if (irq_level !== 3'd0) begin
      failures++;
      $display("[TB] FAIL filter_latency_early: irq_level=%0d required 0", irq_level);
    end
    tick(1);
    checks++;
    if (irq_level !== 3'd5) begin
      failures++;
      $display("[TB] FAIL filter_latency: irq_level=%0d required 5", irq_level);
    end
    tick(1);
    checks++;
    if (irq_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL req_level5: irq_req=%0b required 1", irq_req);
    end
    do_iack(3'd5, 0, 0, 8'd0, 1'b0);
  endtask

  task automatic test_masked();
    sr_mask = 3'd5;
    set_level(3'd5);
    checks++;
    if (irq_req !== 1'b0 || irq_level !== 3'd5) begin
      failures++;
      $display("[TB] FAIL masked_req: req=%0b lvl=%0d required req=0 lvl=5", irq_req, irq_level);
    end
    iack_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++;
      if (bus_fc !== 3'd0 || bus_oe !== 1'b1 || iack_done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL masked_no_bus: fc=%0d oe=%0b done=%0b required 0/1/0", bus_fc, bus_oe, iack_done);
      end
    end
    iack_start = 1'b0;
  endtask

  task automatic test_dtack();
    sr_mask = 3'd0;
    set_level(3'd4);
    do_iack(3'd4, 1, 2, 8'h40, 1'b0);
  endtask

  task automatic test_timeout();
    sr_mask = 3'd1;
    set_level(3'd2);
    do_iack(3'd2, 2, 0, 8'h00, 1'b0);
  endtask

  task automatic test_vpa_dtack_both();
    sr_mask = 3'd0;
    set_level(3'd3);
    do_iack(3'd3, 3, 1, 8'h99, 1'b1);
  endtask

  task automatic test_nmi();
    sr_mask = 3'd7;
    set_level(3'd7);
    checks++;
    if (irq_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL nmi_req: irq_req=%0b required 1", irq_req);
    end
    do_iack(3'd7, 0, 0, 8'd0, 1'b0);
    tick(2);
    checks++;
    if (irq_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL nmi_held_no_retrigger: irq_req=%0b required 0", irq_req);
    end
    set_level(3'd6);
    checks++;
    if (irq_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL nmi_level6_masked: irq_req=%0b required 0", irq_req);
    end
    set_level(3'd7);
    checks++;
    if (irq_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL nmi_retrigger: irq_req=%0b required 1", irq_req);
    end
    do_iack(3'd7, 1, 3, 8'h5A, 1'b0);
    tick(2);
    checks++;
    if (irq_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL nmi_cleared: irq_req=%0b required 0", irq_req);
    end
  endtask

  task automatic test_glitch();
    sr_mask = 3'd7;
    set_level(3'd2);
    cpu_ipl = 3'b000;
    tick(1);
    cpu_ipl = ~3'd2;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++;
      if (irq_level !== 3'd2 || irq_req !== 1'b0) begin
        failures++;
        $display("[TB] FAIL glitch_filtered: lvl=%0d req=%0b required lvl=2 req=0", irq_level, irq_req);
      end
    end
  endtask

  task automatic test_reset_mid();
    sr_mask = 3'd0;
    set_level(3'd3);
    iack_start = 1'b1;
    tick(1);
    iack_start = 1'b0;
    tick(3);
    checks++;
    if (bus_oe !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_in_wait: bus_oe=%0b required 0", bus_oe);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if (bus_oe !== 1'b1 || bus_fc !== 3'd0 || iack_done !== 1'b0 || irq_level !== 3'd0 || iack_vector !== 8'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid: oe=%0b fc=%0d done=%0b lvl=%0d vec=%0d required 1/0/0/0/0",
               bus_oe, bus_fc, iack_done, irq_level, iack_vector);
    end
    last_vec  = 8'd0;
    last_auto = 1'b0;
    bus_vpa = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      checks++;
      if (iack_done !== 1'b0 || bus_oe !== 1'b1) begin
        failures++;
        $display("[TB] FAIL reset_mid_idle: done=%0b oe=%0b required 0/1", iack_done, bus_oe);
      end
    end
    bus_vpa = 1'b1;
  endtask

  task automatic test_freeze();
    sr_mask = 3'd0;
    set_level(3'd3);
    iack_start = 1'b1;
    tick(1);
    iack_start = 1'b0;
    tick(1);
    sub_sync = 1'b0;
    bus_vpa  = 1'b0;
    cpu_ipl  = ~3'd6;
    iack_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++;
      if (bus_oe !== 1'b0 || bus_fc !== 3'd7 || bus_addr !== 3'd3 || iack_done !== 1'b0 ||
          irq_level !== 3'd3 || irq_req !== 1'b1 || iack_vector !== last_vec || iack_auto !== last_auto) begin
        failures++;
        $display("[TB] FAIL freeze: oe=%0b fc=%0d addr=%0d done=%0b lvl=%0d req=%0b vec=%0d auto=%0b required 0/7/3/0/3/1/%0d/%0b",
                 bus_oe, bus_fc, bus_addr, iack_done, irq_level, irq_req, iack_vector, iack_auto,
                 last_vec, last_auto);
      end
    end
    cpu_ipl    = ~3'd3;
    iack_start = 1'b0;
    sub_sync   = 1'b1;
    tick(1);
    checks++;
    if (iack_done !== 1'b1 || iack_vector !== 8'd27 || iack_auto !== 1'b1) begin
      failures++;
      $display("[TB] FAIL freeze_resume: done=%0b vec=%0d auto=%0b required 1/27/1", iack_done, iack_vector, iack_auto);
    end
    bus_vpa = 1'b1;
    tick(1);
    last_vec  = 8'd27;
    last_auto = 1'b1;
  endtask

  task automatic test_random();
    logic [2:0] lvl;
    logic [2:0] mask;
    logic       exp_req;
    for (int i = 0; i < 16; i++) begin
      lvl     = 3'($urandom_range(1, 6));
      mask    = 3'($urandom_range(0, 7));
      exp_req = (lvl > mask);
      sr_mask = mask;
      set_level(lvl);
      checks++;
      if (irq_req !== exp_req || irq_level !== lvl) begin
        failures++;
        $display("[TB] FAIL random_req: lvl=%0d req=%0b required lvl=%0d req=%0b (mask=%0d)",
                 irq_level, irq_req, lvl, exp_req, mask);
      end
      if (exp_req) begin
        do_iack(lvl, $urandom_range(0, 3), $urandom_range(0, 6), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    @(posedge clk_asic);
    test_reset();
    test_basic_vpa();
    test_masked();
    test_dtack();
    test_timeout();
    test_vpa_dtack_both();
    test_nmi();
    test_glitch();
    test_reset_mid();
    test_freeze();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
